rx_hs4_receiver: RTL

//  Receiving end of the 4-phase req/ack bundled-data link between tx and rx clock domains.
//  - Synchronises incoming req into clk, captures data and returns ack.
//  - Buffers received words in a small FIFO and presents them to the local consumer on a

---
 rtl/rx_hs4_receiver_pkg.sv | 25 ++
 rtl/rx_hs4_receiver_if.sv | 24 ++
 rtl/rx_hs4_receiver_sync_ff.sv | 33 +++
 rtl/rx_hs4_receiver.sv | 108 ++++++++++
 4 files changed

// File: rtl/rx_hs4_receiver_pkg.sv
// ---------------------------------------------------------------------------
// rx_hs4_receiver_pkg
// Shared definitions for the receive end of the 4-phase bundled-data link:
// default data width and buffer depth, handshake FSM state encodings, and
// the request synchroniser depth.
// Configuration macro: RX_SYNC3_EN selects a 3-stage req synchroniser
// (adds one clk to both ack edges). Default build uses 2 stages.
// ---------------------------------------------------------------------------
package rx_hs4_receiver_pkg;

  localparam int DATA_MSB_DEF  = 7;
  localparam int BUF_DEPTH_DEF = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

`ifdef RX_SYNC3_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif

endpackage

// File: rtl/rx_hs4_receiver_if.sv
// ---------------------------------------------------------------------------
// rx_hs4_receiver_if
// Bundles the link-side handshake (req/data/ack) and the consumer-side
// valid/ready port (vo/rdata/rready) of the receiver.
//   master : transmitter + consumer view (drives req, data, rready)
//   slave  : receiver view (drives ack, vo, rdata)
// ---------------------------------------------------------------------------
interface rx_hs4_receiver_if
  import rx_hs4_receiver_pkg::*;
#(
  parameter int DATA_MSB = DATA_MSB_DEF
) ();

  logic              req;
  logic [DATA_MSB:0] data;
  logic              ack;
  logic              vo;
  logic [DATA_MSB:0] rdata;
  logic              rready;

  modport master (output req, data, rready, input ack, vo, rdata);
  modport slave  (input req, data, rready, output ack, vo, rdata);

endinterface

// File: rtl/rx_hs4_receiver_sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff
// N-stage single-bit synchroniser with asynchronous active-high reset to 0.
// Ports:
//   clk   in  destination-domain clock
//   reset in  asynchronous reset, active-high
//   d     in  asynchronous input bit
//   q     out synchronised bit (N clk of latency)
// ---------------------------------------------------------------------------
module sync_ff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [N-1:0] stages;

  // NOTE: non-blocking assignments make every stage sample the previous
  // stage's old value, so the chain really is N flops deep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stages <= '0;
    end else begin
      stages <= {stages[N-2:0], d};
    end
  end

  assign q = stages[N-1];

endmodule

// File: rtl/rx_hs4_receiver.sv
// ---------------------------------------------------------------------------
// rx_hs4_receiver
// Receive end of a 4-phase req/ack bundled-data link. The incoming req is
// synchronised into clk; on a synchronised request with buffer room the
// data word is pushed into a small FIFO and ack is raised. ack drops once
// the synchronised req has dropped. The FIFO head is offered to the local
// consumer on a valid/ready port.
// Ports:
//   clk    in     receive-domain clock
//   reset  in     asynchronous reset, active-high
//   bus    slave  req/data in, ack out; vo/rdata out, rready in
// Parameters:
//   DATA_MSB  MSB index of the data word
//   BUF_DEPTH FIFO depth in words (power of 2, >= 2)
// Configuration macro: RX_SYNC3_EN (3-stage req synchroniser).
// ---------------------------------------------------------------------------
module rx_hs4_receiver
  import rx_hs4_receiver_pkg::*;
#(
  parameter int DATA_MSB  = DATA_MSB_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
  input logic              clk,
  input logic              reset,
  rx_hs4_receiver_if.slave bus
);

  localparam int             PTR_W    = $clog2(BUF_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = BUF_DEPTH[PTR_W:0];

  logic              req_s;
  state_t            state, state_nxt;
  logic [DATA_MSB:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              full, vo, push, pop;

  sync_ff #(.N(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.req),
    .q     (req_s)
  );

  // full comes from the registered count only, so a pop on the same edge
  // cannot open room for a push; that push waits one clk.
  assign full = (count == FULL_CNT);
  assign vo   = (count != '0);
  assign pop  = vo && bus.rready;

  // NOTE: every signal written here gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_s && !full) begin
          push      = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!req_s) begin
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // HOLD is encoded as 1, so the state flop is itself the registered ack
  // and reset clears it without waiting for a clk edge.
  assign bus.ack = (state == ST_HOLD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; rdata is forced to 0 while empty, so stale
  // contents are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data;
  end

  assign bus.vo    = vo;
  assign bus.rdata = vo ? mem[rd_ptr] : '0;

endmodule
